// File: rtl/product_bcd_converter_pkg.sv
// Shared types and sizing for the multiplier product display path.
// Holds converter states, the BCD digit type and default widths.
package mult_pkg;

  localparam int DEF_IN_W = 8;
  localparam int DEF_NDIG = 5;
  localparam int DEF_P_W  = 2 * DEF_IN_W;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic int p_w(input int in_w);
    return 2 * in_w;
  endfunction

endpackage

// File: rtl/product_bcd_converter_if.sv
// Host-side bundle for the product-to-BCD converter.
// Master drives the product and start; slave reports status and result.
interface product_bcd_converter_if #(
  parameter int IN_W = 8,
  parameter int NDIG = 5
);

  logic              start;
  logic [IN_W-1:0]   A_in;
  logic [IN_W-1:0]   B_in;
  logic              busy;
  logic              done;
  logic              neg;
  logic [4*NDIG-1:0] bcd;

  modport master (
    output start, A_in, B_in,
    input  busy, done, neg, bcd
  );

  modport slave (
    input  start, A_in, B_in,
    output busy, done, neg, bcd
  );

endinterface

// File: rtl/product_bcd_converter_adjust.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adjust
  import mult_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  always_comb begin
    q = d;
    if (d >= 4'd5)
      q = d + 4'd3;
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: signed product to sign + BCD,
// one product bit per clock, result registers updated only on completion.
module product_bcd_converter
  import mult_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int NDIG = DEF_NDIG
) (
  input  logic                    Clk,
  input  logic                    Reset,
  product_bcd_converter_if.slave  bus
);

  localparam int P_W   = p_w(IN_W);
  localparam int CNT_W = $clog2(P_W + 1);
  localparam int BCD_W = 4 * NDIG;

  conv_state_t        state;
  logic [CNT_W-1:0]   count;
  logic [P_W-1:0]     mag;
  logic [BCD_W-1:0]   scratch;
  logic               neg_r;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_nxt;
  logic [P_W-1:0]     prod;
  logic [P_W-1:0]     prod_abs;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (scratch[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  always_comb begin
    prod     = {bus.A_in, bus.B_in};
    prod_abs = prod;
    if (prod[P_W-1])
      prod_abs = ~prod + P_W'(1);
  end

  // shift the adjusted digits left, pulling in the next magnitude bit
  always_comb begin
    scratch_nxt = (adj << 1)
      | {{(BCD_W-1){1'b0}}, mag[P_W-1]};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      mag      <= '0;
      scratch  <= '0;
      neg_r    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.neg  <= 1'b0;
      bus.bcd  <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            neg_r    <= prod[P_W-1];
            mag      <= prod_abs;
            scratch  <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= scratch_nxt;
          mag     <= mag << 1;
          count   <= count + CNT_W'(1);
          if (count == CNT_W'(P_W - 1)) begin
            bus.bcd  <= scratch_nxt;
            bus.neg  <= neg_r;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized and directed bench for product_bcd_converter
// against an arithmetic sign/magnitude/decimal reference.
module tb_product_bcd_converter;

  logic Clk;
  logic Reset;

  int n_checks = 0;
  int n_fail   = 0;

  product_bcd_converter_if #(.IN_W(8), .NDIG(5)) bus ();

  product_bcd_converter #(.IN_W(8), .NDIG(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_conv(input logic [7:0] a,
                                   input logic [7:0] b,
                                   output logic n,
                                   output logic [19:0] d);
    logic signed [15:0] p;
    int v;
    p = {a, b};
    v = p;
    n = (v < 0);
    if (v < 0) v = -v;
    d = '0;
    for (int i = 0; i < 5; i++) begin
      d[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.A_in  = a;
    bus.B_in  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // counts cycles from acceptance until done, and busy-high samples before it
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    do begin
      tick();
      cyc++;
      if (bus.busy && !bus.done) busy_n++;
    end while (!bus.done && cyc < 60);
  endtask

  task automatic run_one(input string tag,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input bit full);
    logic en;
    logic [19:0] ed;
    int cyc, bn;
    ref_conv(a, b, en, ed);
    launch(a, b);
    if (full) check({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
    wait_done(cyc, bn);
    check({tag, "_lat"}, cyc, 32'd16);
    check({tag, "_neg"}, 32'(bus.neg), 32'(en));
    check({tag, "_bcd"}, 32'(bus.bcd), 32'(ed));
    if (full) begin
      check({tag, "_busy_n"}, bn, 32'd15);
      check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      tick();
      check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic en;
    logic [19:0] ed, hold_bcd;
    logic hold_neg;
    int cyc, bn, dn, first, stable_bad;
    logic [7:0] ra, rb;

    Reset = 1'b0;
    bus.start = 1'b0;
    bus.A_in = '0;
    bus.B_in = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_neg", 32'(bus.neg), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();

    run_one("t1_pos6", 8'h00, 8'h06, 1'b1);
    run_one("t2_neg6", 8'hFF, 8'hFA, 1'b1);
    run_one("t3_min", 8'h80, 8'h00, 1'b1);
    run_one("zero", 8'h00, 8'h00, 1'b0);

    // start pulse and operand change mid-conversion must be ignored
    launch(8'h7F, 8'hFF);
    dn = 0;
    first = 0;
    hold_bcd = '0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.done) begin
        dn++;
        if (first == 0) begin
          first = i;
          hold_bcd = bus.bcd;
        end
      end
      if (i == 5) begin
        bus.start = 1'b1;
        bus.A_in = 8'h00;
        bus.B_in = 8'h01;
      end
      if (i == 6) bus.start = 1'b0;
    end
    check("t4_lat", first, 32'd16);
    check("t4_ndone", dn, 32'd1);
    check("t4_bcd", 32'(hold_bcd), 32'h32767);

    // asynchronous abort mid-conversion
    launch(8'h12, 8'h34);
    for (int i = 0; i < 8; i++) tick();
    Reset = 1'b0;
    #1;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    check("t5_neg", 32'(bus.neg), 32'd0);
    check("t5_bcd", 32'(bus.bcd), 32'd0);
    tick();
    tick();
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    run_one("t5_after", 8'h00, 8'h21, 1'b1);

    // back-to-back conversions with start held high
    bus.A_in = 8'h00;
    bus.B_in = 8'h06;
    bus.start = 1'b1;
    tick();
    bus.A_in = 8'hFF;
    bus.B_in = 8'hFA;
    wait_done(cyc, bn);
    check("t6_lat1", cyc, 32'd16);
    check("t6_bcd1", 32'(bus.bcd), 32'h00006);
    check("t6_neg1", 32'(bus.neg), 32'd0);
    hold_bcd = bus.bcd;
    hold_neg = bus.neg;
    stable_bad = 0;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (!bus.done && (bus.bcd !== hold_bcd || bus.neg !== hold_neg))
        stable_bad++;
      if (cyc == 1) bus.start = 1'b0;
    end while (!bus.done && cyc < 60);
    check("t6_gap", cyc, 32'd17);
    check("t6_stable", stable_bad, 32'd0);
    check("t6_bcd2", 32'(bus.bcd), 32'h00006);
    check("t6_neg2", 32'(bus.neg), 32'd1);
    tick();

    // random products against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ref_conv(ra, rb, en, ed);
      launch(ra, rb);
      wait_done(cyc, bn);
      check($sformatf("rnd%0d_lat", i), cyc, 32'd16);
      check($sformatf("rnd%0d_%h%h", i, ra, rb),
            {11'd0, bus.neg, bus.bcd}, {11'd0, en, ed});
      for (int k = 0; k < 5; k++)
        if (bus.bcd[4*k +: 4] > 4'd9)
          check($sformatf("rnd%0d_dig%0d", i, k),
                32'(bus.bcd[4*k +: 4]), 32'd9);
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
